// File: rtl/uart_midi_tx.sv
// uart_midi_tx: serialises packed MIDI events onto an 8N1 UART line.
// One event per valid/ready handshake; the byte count comes from the status
// byte and an optional running-status filter drops repeated voice status bytes.
// Synchronous, active-low reset on rst_in.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | line high, ready for an event
// S_START | start bit (line low) for one bit period
// S_DATA  | eight data bits, LSB first, one bit period each
// S_STOP  | stop bit (line high); then next byte or back to idle

module uart_midi_tx #(
    parameter int CLK_HZ         = 98_333_333,
    parameter int BAUD           = 31_250,
    parameter bit RUNNING_STATUS = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        valid_in,
    input  logic [23:0] midi_bytes,
    output logic        ready_out,
    output logic        tx_out,
    output logic        busy_out,
    output logic        done_out
);

    localparam int CYCLES_PER_BIT = CLK_HZ / BAUD;
    localparam int TIMER_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CYCLES_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t              state;
    logic [TIMER_W-1:0]  bit_timer;
    logic [2:0]          bit_idx;
    logic [1:0]          bytes_left;
    logic [7:0]          shift_reg;
    logic [15:0]         pending;
    logic [7:0]          last_status;

    logic [7:0]          status;
    logic [1:0]          ev_len;
    logic                is_voice;
    logic                is_common;
    logic                skip_status;
    logic [7:0]          first_byte;
    logic [15:0]         rest_bytes;
    logic [1:0]          rest_count;
    logic                bit_wrap;

    // Decode the incoming event: length, status class and what goes on the line first.
    always_comb begin
        status      = midi_bytes[23:16];
        ev_len      = 2'd0;
        is_voice    = status[7] && (status[7:4] != 4'hF);
        is_common   = (status[7:3] == 5'b11110);
        if (status[7]) begin
            case (status[7:4])
                4'h8, 4'h9, 4'hA, 4'hB, 4'hE: ev_len = 2'd3;
                4'hC, 4'hD:                   ev_len = 2'd2;
                default: begin
                    case (status)
                        8'hF1, 8'hF3: ev_len = 2'd2;
                        8'hF2:        ev_len = 2'd3;
                        default:      ev_len = 2'd1;
                    endcase
                end
            endcase
        end
        // Voice messages always carry data, so a skipped status never empties the event.
        skip_status = RUNNING_STATUS && is_voice && (status == last_status);
        if (skip_status) begin
            first_byte = midi_bytes[15:8];
            rest_bytes = {midi_bytes[7:0], 8'h00};
            rest_count = ev_len - 2'd2;
        end else begin
            first_byte = status;
            rest_bytes = midi_bytes[15:0];
            rest_count = (ev_len == 2'd0) ? 2'd0 : ev_len - 2'd1;
        end
        bit_wrap = (bit_timer == TIMER_LAST);
    end

    // Transmit FSM with bit timer, byte sequencing, running-status memory and registered outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state       <= S_IDLE;
            bit_timer   <= '0;
            bit_idx     <= 3'd0;
            bytes_left  <= 2'd0;
            shift_reg   <= 8'h00;
            pending     <= 16'h0000;
            last_status <= 8'h00;
            tx_out      <= 1'b1;
            ready_out   <= 1'b1;
            busy_out    <= 1'b0;
            done_out    <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    bit_timer <= '0;
                    if (valid_in) begin
                        // Realtime (F8-FF) and invalid statuses leave the memory alone.
                        if (is_voice) begin
                            last_status <= status;
                        end else if (is_common) begin
                            last_status <= 8'h00;
                        end
                        if (ev_len != 2'd0) begin
                            state      <= S_START;
                            tx_out     <= 1'b0;
                            ready_out  <= 1'b0;
                            busy_out   <= 1'b1;
                            shift_reg  <= first_byte;
                            pending    <= rest_bytes;
                            bytes_left <= rest_count;
                        end
                    end
                end
                S_START: begin
                    if (bit_wrap) begin
                        bit_timer <= '0;
                        bit_idx   <= 3'd0;
                        state     <= S_DATA;
                        tx_out    <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_wrap) begin
                        bit_timer <= '0;
                        if (bit_idx == 3'd7) begin
                            state  <= S_STOP;
                            tx_out <= 1'b1;
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            tx_out    <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_wrap) begin
                        bit_timer <= '0;
                        if (bytes_left != 2'd0) begin
                            // Next byte starts immediately, no idle gap between bytes.
                            state      <= S_START;
                            tx_out     <= 1'b0;
                            shift_reg  <= pending[15:8];
                            pending    <= {pending[7:0], 8'h00};
                            bytes_left <= bytes_left - 2'd1;
                        end else begin
                            state     <= S_IDLE;
                            tx_out    <= 1'b1;
                            ready_out <= 1'b1;
                            busy_out  <= 1'b0;
                            done_out  <= 1'b1;
                        end
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    tx_out    <= 1'b1;
                    ready_out <= 1'b1;
                    busy_out  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_midi_tx.sv
// Bench for uart_midi_tx: two instances (running status on/off) share stimulus;
// a line receiver on each output collects bytes and a behavioural MIDI model
// predicts the byte streams and frame timing.

module tb_uart_midi_tx;

    localparam int CLK_HZ = 80;
    localparam int BAUD   = 10;
    localparam int C      = CLK_HZ / BAUD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [23:0] ev;
    logic [1:0]  ready_v, tx_v, busy_v, done_v;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_midi_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .RUNNING_STATUS(1'b1)) dut (
        .clk_in(clk), .rst_in(rst_n), .valid_in(valid), .midi_bytes(ev),
        .ready_out(ready_v[0]), .tx_out(tx_v[0]), .busy_out(busy_v[0]), .done_out(done_v[0])
    );

    uart_midi_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .RUNNING_STATUS(1'b0)) dut_nrs (
        .clk_in(clk), .rst_in(rst_n), .valid_in(valid), .midi_bytes(ev),
        .ready_out(ready_v[1]), .tx_out(tx_v[1]), .busy_out(busy_v[1]), .done_out(done_v[1])
    );

    // ---------------- line receivers ----------------
    logic [7:0] got0[$], got1[$];
    logic [7:0] exp0[$], exp1[$];
    logic       mon_act[2];
    int         mon_cnt[2];
    logic [7:0] mon_sh[2];
    int         frame_err[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            mon_act[i] = 1'b0;
            mon_cnt[i] = 0;
            mon_sh[i] = 8'h00;
            frame_err[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mon_act[i] <= 1'b0;
            end else if (!mon_act[i]) begin
                if (tx_v[i] == 1'b0) begin
                    mon_act[i] <= 1'b1;
                    mon_cnt[i] <= 1;
                end
            end else begin
                if (mon_cnt[i] >= C + C/2 && mon_cnt[i] < 9*C + C/2 && ((mon_cnt[i] - C/2) % C) == 0)
                    mon_sh[i] <= {tx_v[i], mon_sh[i][7:1]};
                if (mon_cnt[i] == 9*C + C/2) begin
                    if (tx_v[i] == 1'b1) begin
                        if (i == 0) got0.push_back(mon_sh[i]);
                        else        got1.push_back(mon_sh[i]);
                    end else begin
                        frame_err[i] <= frame_err[i] + 1;
                    end
                    mon_act[i] <= 1'b0;
                end
                mon_cnt[i] <= mon_cnt[i] + 1;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] m_last[2];

    // Appends the expected line bytes for both instances; returns the byte count of the running-status one.
    function automatic int model_event(input logic [23:0] e);
        logic [7:0] s;
        logic [7:0] b[3];
        int len, first, n0;
        s = e[23:16];
        b[0] = s; b[1] = e[15:8]; b[2] = e[7:0];
        if (s < 8'h80)                   len = 0;
        else if (s < 8'hC0)              len = 3;
        else if (s < 8'hE0)              len = 2;
        else if (s < 8'hF0)              len = 3;
        else if (s == 8'hF1 || s == 8'hF3) len = 2;
        else if (s == 8'hF2)             len = 3;
        else                             len = 1;
        n0 = 0;
        for (int i = 0; i < 2; i++) begin
            first = (i == 0 && s >= 8'h80 && s < 8'hF0 && s == m_last[i]) ? 1 : 0;
            for (int k = first; k < len; k++) begin
                if (i == 0) exp0.push_back(b[k]);
                else        exp1.push_back(b[k]);
            end
            if (i == 0) n0 = (len == 0) ? 0 : len - first;
            if (s >= 8'h80 && s < 8'hF0)      m_last[i] = s;
            else if (s >= 8'hF0 && s < 8'hF8) m_last[i] = 8'h00;
        end
        return n0;
    endfunction

    // ---------------- drivers ----------------
    task automatic send(input logic [23:0] e, output int n0);
        int g = 0;
        while (ready_v !== 2'b11 && g < 5000) begin
            @(posedge clk); #1; g++;
        end
        if (g >= 5000) begin
            n_cmp++; n_err++;
            $display("FAIL send_wait_ready: ready=%b after %0d cycles, wanted 11", ready_v, g);
        end
        valid = 1'b1;
        ev = e;
        n0 = model_event(e);
        @(posedge clk); #1;
        valid = 1'b0;
        ev = $urandom;
    endtask

    // Counts edges from accept+1 until the running-status instance pulses done.
    task automatic wait_done(output int k);
        k = 0;
        while (done_v[0] !== 1'b1 && k < 5000) begin
            @(posedge clk); #1; k++;
        end
        n_cmp++;
        if (ready_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
            n_err++;
            $display("FAIL done_flags: ready=%b busy=%b at done, wanted 1/0", ready_v[0], busy_v[0]);
        end
    endtask

    task automatic check_lines(input string tag);
        int g = 0;
        while ((ready_v !== 2'b11 || mon_act[0] || mon_act[1]) && g < 5000) begin
            @(posedge clk); #1; g++;
        end
        n_cmp++;
        if (g >= 5000) begin
            n_err++;
            $display("FAIL %s_settle: still busy after %0d cycles, wanted idle", tag, g);
        end
        n_cmp++;
        if (got0.size() != exp0.size()) begin
            n_err++;
            $display("FAIL %s_count_rs: got %0d bytes, wanted %0d", tag, got0.size(), exp0.size());
        end
        for (int k = 0; k < exp0.size() && k < got0.size(); k++) begin
            n_cmp++;
            if (got0[k] !== exp0[k]) begin
                n_err++;
                $display("FAIL %s_byte_rs[%0d]: got %h, wanted %h", tag, k, got0[k], exp0[k]);
            end
        end
        n_cmp++;
        if (got1.size() != exp1.size()) begin
            n_err++;
            $display("FAIL %s_count_nrs: got %0d bytes, wanted %0d", tag, got1.size(), exp1.size());
        end
        for (int k = 0; k < exp1.size() && k < got1.size(); k++) begin
            n_cmp++;
            if (got1[k] !== exp1[k]) begin
                n_err++;
                $display("FAIL %s_byte_nrs[%0d]: got %h, wanted %h", tag, k, got1[k], exp1[k]);
            end
        end
        n_cmp++;
        if (frame_err[0] != 0 || frame_err[1] != 0) begin
            n_err++;
            $display("FAIL %s_framing: errors %0d/%0d, wanted 0/0", tag, frame_err[0], frame_err[1]);
        end
        got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        ev = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (tx_v !== 2'b11)    begin n_err++; $display("FAIL reset_tx: got %b, wanted 11", tx_v); end
        n_cmp++; if (ready_v !== 2'b11) begin n_err++; $display("FAIL reset_ready: got %b, wanted 11", ready_v); end
        n_cmp++; if (busy_v !== 2'b00)  begin n_err++; $display("FAIL reset_busy: got %b, wanted 00", busy_v); end
        n_cmp++; if (done_v !== 2'b00)  begin n_err++; $display("FAIL reset_done: got %b, wanted 00", done_v); end
        rst_n = 1'b1;
        m_last[0] = 8'h00; m_last[1] = 8'h00;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int n, k;
        send(24'h903C64, n);
        n_cmp++; if (tx_v !== 2'b00)    begin n_err++; $display("FAIL basic_start: tx=%b at accept+1, wanted 00", tx_v); end
        n_cmp++; if (busy_v !== 2'b11)  begin n_err++; $display("FAIL basic_busy: got %b, wanted 11", busy_v); end
        n_cmp++; if (ready_v !== 2'b00) begin n_err++; $display("FAIL basic_ready: got %b, wanted 00", ready_v); end
        wait_done(k);
        n_cmp++; if (k != 30*C) begin n_err++; $display("FAIL basic_frame_len: done after %0d cycles, wanted %0d", k, 30*C); end
        check_lines("basic");
    endtask

    task automatic test_running_status();
        int n, k;
        send(24'h904064, n);
        wait_done(k);
        n_cmp++; if (k != 20*C) begin n_err++; $display("FAIL rs_frame_len: done after %0d cycles, wanted %0d", k, 20*C); end
        check_lines("running_status");
    endtask

    task automatic test_realtime();
        int n, k;
        send({8'hC0, 8'h05, 8'($urandom)}, n);
        wait_done(k);
        n_cmp++; if (k != 20*C) begin n_err++; $display("FAIL rt_prog_len: got %0d cycles, wanted %0d", k, 20*C); end
        check_lines("prog_change");
        send({8'hF8, 16'($urandom)}, n);
        wait_done(k);
        n_cmp++; if (k != 10*C) begin n_err++; $display("FAIL rt_clock_len: got %0d cycles, wanted %0d", k, 10*C); end
        check_lines("realtime");
        send({8'hC0, 8'h07, 8'($urandom)}, n);
        wait_done(k);
        n_cmp++; if (k != 10*C) begin n_err++; $display("FAIL rt_resume_len: got %0d cycles, wanted %0d", k, 10*C); end
        check_lines("after_realtime");
    endtask

    task automatic test_invalid();
        int n, bad;
        for (int it = 0; it < 4; it++) begin
            logic [23:0] e;
            e = (it == 0) ? 24'h123456 : {1'b0, 7'($urandom), 16'($urandom)};
            send(e, n);
            bad = 0;
            for (int c = 0; c < 4*C; c++) begin
                if (tx_v !== 2'b11 || ready_v !== 2'b11 || busy_v !== 2'b00 || done_v !== 2'b00) bad++;
                @(posedge clk); #1;
            end
            n_cmp++;
            if (bad != 0) begin
                n_err++;
                $display("FAIL invalid_idle: status %h disturbed outputs in %0d cycles, wanted 0", e[23:16], bad);
            end
        end
        check_lines("invalid");
    endtask

    task automatic test_random();
        int n, k;
        logic [7:0] s;
        for (int it = 0; it < 20; it++) begin
            case ($urandom_range(0, 5))
                0:       s = (m_last[0] != 8'h00) ? m_last[0] : 8'h9F;
                1:       s = 8'hF0 | 8'($urandom_range(0, 15));
                2:       s = 8'($urandom_range(0, 127));
                default: s = 8'h80 | 8'($urandom_range(0, 8'h6F));
            endcase
            send({s, 16'($urandom)}, n);
            if (n > 0) begin
                wait_done(k);
                n_cmp++;
                if (k != 10*n*C) begin
                    n_err++;
                    $display("FAIL random_frame_len: status %h done after %0d cycles, wanted %0d", s, k, 10*n*C);
                end
            end
            check_lines("random");
        end
    endtask

    task automatic test_back_to_back();
        int n1, n2, k, g;
        logic [7:0]  s1;
        logic [23:0] e1, e2;
        g = 0;
        while (ready_v !== 2'b11 && g < 5000) begin @(posedge clk); #1; g++; end
        s1 = 8'h80 | 8'($urandom_range(0, 8'h6F));
        while (s1 == m_last[0]) s1 = 8'h80 | 8'($urandom_range(0, 8'h6F));
        e1 = {s1, 16'($urandom)};
        e2 = {8'h80 | 8'($urandom_range(0, 8'h6F)), 16'($urandom)};
        valid = 1'b1;
        ev = e1;
        n1 = model_event(e1);
        @(posedge clk); #1;
        k = 0;
        while (k < 5000) begin
            ev = $urandom;
            @(posedge clk); #1; k++;
            if (done_v[0] === 1'b1) break;
        end
        n_cmp++; if (k != 10*n1*C) begin n_err++; $display("FAIL b2b_first_len: done after %0d cycles, wanted %0d", k, 10*n1*C); end
        n_cmp++; if (ready_v !== 2'b11) begin n_err++; $display("FAIL b2b_ready_at_done: got %b, wanted 11", ready_v); end
        ev = e2;
        n2 = model_event(e2);
        @(posedge clk); #1;
        valid = 1'b0;
        n_cmp++; if (tx_v !== 2'b00)   begin n_err++; $display("FAIL b2b_second_start: tx=%b, wanted 00", tx_v); end
        n_cmp++; if (busy_v !== 2'b11) begin n_err++; $display("FAIL b2b_second_busy: got %b, wanted 11", busy_v); end
        wait_done(k);
        n_cmp++; if (k != 10*n2*C) begin n_err++; $display("FAIL b2b_second_len: done after %0d cycles, wanted %0d", k, 10*n2*C); end
        check_lines("back_to_back");
    endtask

    task automatic test_mid_reset();
        int n, k;
        send({8'hF6, 16'($urandom)}, n);
        check_lines("tune_request");
        send(24'h903C64, n);
        repeat (14*C + C/2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_cmp++; if (tx_v !== 2'b11)    begin n_err++; $display("FAIL midrst_tx: got %b, wanted 11", tx_v); end
        n_cmp++; if (ready_v !== 2'b11) begin n_err++; $display("FAIL midrst_ready: got %b, wanted 11", ready_v); end
        n_cmp++; if (busy_v !== 2'b00)  begin n_err++; $display("FAIL midrst_busy: got %b, wanted 00", busy_v); end
        n_cmp++; if (done_v !== 2'b00)  begin n_err++; $display("FAIL midrst_done: got %b, wanted 00", done_v); end
        exp0.delete(); exp1.delete();
        exp0.push_back(8'h90); exp1.push_back(8'h90);
        m_last[0] = 8'h00; m_last[1] = 8'h00;
        check_lines("mid_reset");
        send(24'h903C64, n);
        wait_done(k);
        n_cmp++; if (k != 30*C) begin n_err++; $display("FAIL midrst_resend_len: done after %0d cycles, wanted %0d", k, 30*C); end
        check_lines("after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_running_status();
        test_realtime();
        test_invalid();
        test_random();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, wanted completion");
        $fatal(1, "watchdog expired");
    end

endmodule
